dram_sdp_ext: RTL and testbench
===============================

Name: dram_sdp_ext

Overview:
Parametrised simple-dual-port distributed RAM, the successor to the basic SDP RAM used for the CPU's small tables (BTB, PHT, TLB shadow).
- Adds per-byte write enables and selectable read latency (0/1/2).
- Adds a configurable same-address read/write collision policy with write-data forwarding.
- Adds a self-timed clear engine that zeroes the whole array, one word per cycle.
- One write port and one read port share one clock.

Parameters:
RAM_WIDTH, 32, word width in bits; must be a multiple of 8.
RAM_DEPTH, 256, number of words; any value >= 2.
READ_LATENCY, 1, cycles from en_r to dout_r; legal values 0, 1, 2.
COLLISION, "WRITE_FIRST", same-address same-cycle policy; "WRITE_FIRST" or "READ_FIRST".
INIT_FILE, "", hex init file loaded with $readmemh; empty string means zero-init.
Derived: AW = clogb2(RAM_DEPTH-1); NB = RAM_WIDTH/8.

Ports:
clk  in  1  clock; all state on rising edge.
rst  in  1  synchronous active-high reset.
addr_w  in  AW  write address.
din_w  in  RAM_WIDTH  write data.
we_w  in  NB  byte write enables; bit i writes din_w[8i+7:8i].
addr_r  in  AW  read address.
en_r  in  1  read request.
dout_r  out  RAM_WIDTH  read data.
dout_valid  out  1  dout_r holds data for a request issued READ_LATENCY cycles earlier.
clr_req  in  1  single-cycle pulse that starts an array clear.
clr_busy  out  1  clear sweep in progress.

Behaviour:
- Reset: clock and reset behaviour is fixed as one clock, synchronous active-high reset.
  - rst clears the FSM to IDLE, the clear counter to 0, all pipeline data registers to 0 and all valid bits to 0.
  - Array contents are not reset.
  - After reset: dout_valid=0, clr_busy=0. dout_r=0 when READ_LATENCY>=1.
- Write:
  - At the edge, each lane i with we_w[i]=1 and clr_busy=0 updates ram[addr_w] lane i.
  - Other lanes are unchanged.
  - Writes with clr_busy=1 are dropped silently.
- Read, READ_LATENCY=0:
  - dout_r is combinational from ram[addr_r]. dout_valid=en_r.
- Read, READ_LATENCY=1:
  - When en_r=1, register R1 captures the word at the edge.
  - When en_r=0, R1 holds its value.
  - dout_r=R1. dout_valid = en_r delayed 1 cycle.
- Read, READ_LATENCY=2:
  - R2 <= R1 every cycle.
  - dout_r=R2. dout_valid = en_r delayed 2 cycles.
- Collision (addr_r==addr_w, any we_w bit set, clr_busy=0):
  - WRITE_FIRST: read data is the merge. Lanes with we_w=1 take din_w; other lanes take the stored word. This applies combinationally at latency 0 and to the captured R1 at latencies 1 and 2.
  - READ_FIRST: read data is the stored pre-write word.
  - A write to addr_w at cycle t is visible to any read issued at t+1 or later.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_req=1. In that transition cycle the counter is loaded with 0 and clr_busy becomes 1 on the next cycle.
  - In CLEAR, each cycle writes all-zero to ram[cnt] and increments cnt.
  - After writing address RAM_DEPTH-1, return to IDLE. clr_busy falls the following cycle.
  - Total clr_busy high time is exactly RAM_DEPTH cycles.
  - clr_req while in CLEAR is ignored; no restart.
  - rst during CLEAR aborts the sweep. Already-zeroed words stay zero; the rest keep their contents.
  - The counter never wraps beyond RAM_DEPTH-1, including for non-power-of-2 depths.
- Reads during CLEAR remain legal.
  - They return current array contents, where swept words are already zero.
  - No forwarding from the sweep is applied.
- Simultaneous clr_req and external write in the same IDLE cycle: the write is performed, then the sweep starts.
- Out-of-range addresses (>= RAM_DEPTH, non-power-of-2 depth):
  - Writes are dropped.
  - Reads return 0.

Test Plan:
- Byte write, W=32 D=16 L=1: write 0xAABBCCDD to addr 3 with we=4'hF, then 0x11223344 with we=4'b0101. Read addr 3 -> dout_r=0xAA22CC44, dout_valid high exactly 1 cycle after en_r.
- Collision WRITE_FIRST, L=1: ram[5]=0x0. In the same cycle, write 0xCAFEF00D to addr 5 with we=4'b0011 and read addr 5 -> dout_r=0x0000F00D. Repeat with READ_FIRST -> 0x00000000.
- Latency 2: en_r pulses at cycles 10 and 11 for addrs 1 and 2 (preloaded 0x1 and 0x2) -> dout_valid high at cycles 12 and 13 with 0x1 then 0x2. R2 holds 0x2 afterwards while dout_valid=0.
- Clear, D=16: preload all words with 0xFFFFFFFF and pulse clr_req at cycle 0 -> clr_busy high for cycles 1..16. A write at cycle 5 is dropped. After clr_busy falls, all 16 reads return 0.
- Reset mid-clear, D=16: pulse clr_req at 0 and rst at cycle 6 -> clr_busy=0 at cycle 7, words 0..4 read 0, words 5..15 keep 0xFFFFFFFF. A new clr_req restarts from addr 0.
- Reset outputs, L=2: assert rst with an en_r pipeline in flight -> next cycle dout_r=0, dout_valid=0, clr_busy=0. Array contents are preserved.

Source files
------------

// File: rtl/dram_sdp_ext.sv
// Simple-dual-port distributed RAM with byte enables, 0/1/2-cycle read latency,
// same-address collision policy and a self-timed zeroing sweep.
module dram_sdp_ext #(
  parameter int    RAM_WIDTH    = 32,
  parameter int    RAM_DEPTH    = 256,
  parameter int    READ_LATENCY = 1,
  parameter string COLLISION    = "WRITE_FIRST",
  parameter string INIT_FILE    = "",
  localparam int   AW           = $clog2(RAM_DEPTH),
  localparam int   NB           = RAM_WIDTH / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        addr_w,
  input  logic [RAM_WIDTH-1:0] din_w,
  input  logic [NB-1:0]        we_w,
  input  logic [AW-1:0]        addr_r,
  input  logic                 en_r,
  output logic [RAM_WIDTH-1:0] dout_r,
  output logic                 dout_valid,
  input  logic                 clr_req,
  output logic                 clr_busy
);

  localparam bit            WF      = (COLLISION == "WRITE_FIRST");
  localparam logic [AW-1:0] LAST    = AW'(RAM_DEPTH - 1);
  localparam logic [AW:0]   DEPTH_V = (AW + 1)'(RAM_DEPTH);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e               state_q;
  logic [AW-1:0]        cnt_q;
  logic                 clr_busy_q;
  logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];

  logic                 wr_hit;
  logic                 rd_in_rng;
  logic [RAM_WIDTH-1:0] rd_stored;
  logic [RAM_WIDTH-1:0] rd_d;

  function automatic logic [RAM_WIDTH-1:0] lane_merge(input logic [RAM_WIDTH-1:0] old_w,
                                                      input logic [RAM_WIDTH-1:0] new_w,
                                                      input logic [NB-1:0]        be);
    lane_merge = old_w;
    for (int i = 0; i < NB; i++)
      if (be[i]) lane_merge[8*i +: 8] = new_w[8*i +: 8];
  endfunction

  // Clear sweep: counter is loaded on entry and stops exactly at the last word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      clr_busy_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            state_q    <= CLEAR;
            cnt_q      <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          if (cnt_q == LAST) begin
            state_q    <= IDLE;
            clr_busy_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= IDLE;
          clr_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy = clr_busy_q;
  assign wr_hit   = ({1'b0, addr_w} < DEPTH_V) && (|we_w) && !clr_busy_q;

  // A reset in the middle of a sweep must not zero the word under the counter.
  always_ff @(posedge clk) begin
    if (clr_busy_q && !rst) begin
      mem[cnt_q] <= '0;
    end else if (wr_hit) begin
      for (int i = 0; i < NB; i++)
        if (we_w[i]) mem[addr_w][8*i +: 8] <= din_w[8*i +: 8];
    end
  end

  always_comb begin
    rd_in_rng = ({1'b0, addr_r} < DEPTH_V);
    rd_stored = rd_in_rng ? mem[addr_r] : '0;
    rd_d      = rd_stored;
    if (WF && wr_hit && (addr_r == addr_w))
      rd_d = lane_merge(rd_stored, din_w, we_w);
  end

  if (READ_LATENCY == 0) begin : g_lat0
    assign dout_r     = rd_d;
    assign dout_valid = en_r;
  end else begin : g_latn
    logic [RAM_WIDTH-1:0] rd_p1_q;
    logic                 vld_p1_q;

    // Stage 1: capture on request, hold otherwise.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_p1_q  <= '0;
        vld_p1_q <= 1'b0;
      end else begin
        vld_p1_q <= en_r;
        if (en_r) rd_p1_q <= rd_d;
      end
    end

    if (READ_LATENCY == 1) begin : g_lat1
      assign dout_r     = rd_p1_q;
      assign dout_valid = vld_p1_q;
    end else begin : g_lat2
      logic [RAM_WIDTH-1:0] rd_p2_q;
      logic                 vld_p2_q;

      // Stage 2: free-running copy of stage 1.
      always_ff @(posedge clk) begin
        if (rst) begin
          rd_p2_q  <= '0;
          vld_p2_q <= 1'b0;
        end else begin
          rd_p2_q  <= rd_p1_q;
          vld_p2_q <= vld_p1_q;
        end
      end

      assign dout_r     = rd_p2_q;
      assign dout_valid = vld_p2_q;
    end
  end

endmodule

// File: tb/tb_dram_sdp_ext.sv
// Directed bench for dram_sdp_ext: four instances (L1 write-first, L1 read-first,
// L2 write-first, L0 write-first with non-power-of-2 depth) share one stimulus.
module tb_dram_sdp_ext;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  addr_w, addr_r;
  logic [31:0] din_w;
  logic [3:0]  we_w;
  logic        en_r, clr_req;

  logic [31:0] dout_wf, dout_rf, dout_l2, dout_l0;
  logic        vld_wf, vld_rf, vld_l2, vld_l0;
  logic        busy_wf, busy_rf, busy_l2, busy_l0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dram_sdp_ext #(.RAM_WIDTH(32), .RAM_DEPTH(16), .READ_LATENCY(1), .COLLISION("WRITE_FIRST")) u_wf (
    .clk(clk), .rst(rst), .addr_w(addr_w), .din_w(din_w), .we_w(we_w), .addr_r(addr_r),
    .en_r(en_r), .dout_r(dout_wf), .dout_valid(vld_wf), .clr_req(clr_req), .clr_busy(busy_wf));
  dram_sdp_ext #(.RAM_WIDTH(32), .RAM_DEPTH(16), .READ_LATENCY(1), .COLLISION("READ_FIRST")) u_rf (
    .clk(clk), .rst(rst), .addr_w(addr_w), .din_w(din_w), .we_w(we_w), .addr_r(addr_r),
    .en_r(en_r), .dout_r(dout_rf), .dout_valid(vld_rf), .clr_req(clr_req), .clr_busy(busy_rf));
  dram_sdp_ext #(.RAM_WIDTH(32), .RAM_DEPTH(16), .READ_LATENCY(2), .COLLISION("WRITE_FIRST")) u_l2 (
    .clk(clk), .rst(rst), .addr_w(addr_w), .din_w(din_w), .we_w(we_w), .addr_r(addr_r),
    .en_r(en_r), .dout_r(dout_l2), .dout_valid(vld_l2), .clr_req(clr_req), .clr_busy(busy_l2));
  dram_sdp_ext #(.RAM_WIDTH(32), .RAM_DEPTH(10), .READ_LATENCY(0), .COLLISION("WRITE_FIRST")) u_l0 (
    .clk(clk), .rst(rst), .addr_w(addr_w), .din_w(din_w), .we_w(we_w), .addr_r(addr_r),
    .en_r(en_r), .dout_r(dout_l0), .dout_valid(vld_l0), .clr_req(clr_req), .clr_busy(busy_l0));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    addr_w = a; din_w = d; we_w = be;
    step();
    we_w = 4'h0;
  endtask

  task automatic fill_ones();
    for (int i = 0; i < 16; i++) wr(4'(i), 32'hFFFF_FFFF, 4'hF);
  endtask

  initial begin
    int n16, n10;
    rst = 1'b1; addr_w = '0; addr_r = '0; din_w = '0; we_w = '0; en_r = 1'b0; clr_req = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_dout_l1", dout_wf, 32'h0);
    chk("rst_vld_l1", {31'b0, vld_wf}, 32'h0);
    chk("rst_dout_l2", dout_l2, 32'h0);
    chk("rst_busy", {31'b0, busy_wf}, 32'h0);

    // Byte-enable merge
    wr(4'd3, 32'hAABB_CCDD, 4'hF);
    wr(4'd3, 32'h1122_3344, 4'b0101);
    addr_r = 4'd3; en_r = 1'b1;
    #1;
    chk("l0_comb_data", dout_l0, 32'hAA22_CC44);
    chk("l0_comb_vld", {31'b0, vld_l0}, 32'h1);
    step(); en_r = 1'b0;
    chk("byte_l1_data", dout_wf, 32'hAA22_CC44);
    chk("byte_l1_vld", {31'b0, vld_wf}, 32'h1);
    chk("byte_l2_vld_early", {31'b0, vld_l2}, 32'h0);
    step();
    chk("byte_l1_vld_drop", {31'b0, vld_wf}, 32'h0);
    chk("byte_l1_hold", dout_wf, 32'hAA22_CC44);
    chk("byte_l2_data", dout_l2, 32'hAA22_CC44);
    chk("byte_l2_vld", {31'b0, vld_l2}, 32'h1);

    // Same-address collision
    wr(4'd5, 32'h0, 4'hF);
    addr_w = 4'd5; din_w = 32'hCAFE_F00D; we_w = 4'b0011; addr_r = 4'd5; en_r = 1'b1;
    #1;
    chk("coll_l0_wf", dout_l0, 32'h0000_F00D);
    step(); we_w = 4'h0;
    chk("coll_l1_wf", dout_wf, 32'h0000_F00D);
    chk("coll_l1_rf", dout_rf, 32'h0000_0000);
    step(); en_r = 1'b0;
    chk("coll_rf_next", dout_rf, 32'h0000_F00D);

    // Latency 2 back-to-back
    wr(4'd1, 32'h1, 4'hF);
    wr(4'd2, 32'h2, 4'hF);
    addr_r = 4'd1; en_r = 1'b1;
    step();
    chk("l2_vld_a", {31'b0, vld_l2}, 32'h0);
    addr_r = 4'd2;
    step(); en_r = 1'b0;
    chk("l2_vld_b", {31'b0, vld_l2}, 32'h1);
    chk("l2_data_b", dout_l2, 32'h1);
    step();
    chk("l2_vld_c", {31'b0, vld_l2}, 32'h1);
    chk("l2_data_c", dout_l2, 32'h2);
    step();
    chk("l2_vld_d", {31'b0, vld_l2}, 32'h0);
    chk("l2_hold_d", dout_l2, 32'h2);

    // Out-of-range on depth 10
    wr(4'd12, 32'h1234_5678, 4'hF);
    addr_r = 4'd12; en_r = 1'b1;
    #1;
    chk("oor_l0_read", dout_l0, 32'h0);
    step(); en_r = 1'b0;
    chk("oor_d16_read", dout_wf, 32'h1234_5678);

    // Full clear with a dropped write
    fill_ones();
    clr_req = 1'b1;
    step(); clr_req = 1'b0;
    n16 = 0; n10 = 0;
    for (int k = 1; k <= 30; k++) begin
      if (busy_wf) n16++;
      if (busy_l0) n10++;
      if (k == 5) begin addr_w = 4'd0; din_w = 32'hDEAD_BEEF; we_w = 4'hF; end
      else we_w = 4'h0;
      step();
    end
    we_w = 4'h0;
    chk("clr_busy_cycles_d16", 32'(n16), 32'd16);
    chk("clr_busy_cycles_d10", 32'(n10), 32'd10);
    for (int i = 0; i < 16; i++) begin
      addr_r = 4'(i); en_r = 1'b1;
      step();
      chk($sformatf("clr_word%0d", i), dout_wf, 32'h0);
    end
    en_r = 1'b0;

    // Reset aborts the sweep
    fill_ones();
    clr_req = 1'b1;
    step(); clr_req = 1'b0;
    for (int k = 0; k < 5; k++) step();
    rst = 1'b1;
    step(); rst = 1'b0;
    chk("abort_busy", {31'b0, busy_wf}, 32'h0);
    for (int i = 0; i < 16; i++) begin
      addr_r = 4'(i); en_r = 1'b1;
      step();
      chk($sformatf("abort_word%0d", i), dout_wf, (i < 5) ? 32'h0 : 32'hFFFF_FFFF);
    end
    en_r = 1'b0;
    wr(4'd0, 32'h55, 4'hF);
    clr_req = 1'b1;
    step(); clr_req = 1'b0;
    step();
    rst = 1'b1;
    step(); rst = 1'b0;
    addr_r = 4'd0; en_r = 1'b1;
    step();
    chk("restart_word0", dout_wf, 32'h0);
    addr_r = 4'd5;
    step(); en_r = 1'b0;
    chk("restart_word5", dout_wf, 32'hFFFF_FFFF);

    // Reset with a read pipeline in flight
    addr_r = 4'd7; en_r = 1'b1;
    step();
    rst = 1'b1;
    step(); rst = 1'b0; en_r = 1'b0;
    chk("rstpipe_l2_dout", dout_l2, 32'h0);
    chk("rstpipe_l2_vld", {31'b0, vld_l2}, 32'h0);
    chk("rstpipe_busy", {31'b0, busy_l2}, 32'h0);
    chk("rstpipe_l1_dout", dout_wf, 32'h0);
    addr_r = 4'd7; en_r = 1'b1;
    step(); en_r = 1'b0;
    chk("rstpipe_array_kept", dout_wf, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
